xor_arbiter: RTL and testbench
==============================

XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, NREQ, per-requester operand-valid.
REQ-006 The block SHALL have port req_ready, output, NREQ, per-requester accept; one-hot or zero.
REQ-007 The block SHALL have port req_a, input, NREQ*WIDTH, operand A; requester i in slice [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_b, input, NREQ*WIDTH, operand B; same packing as req_a.
REQ-009 The block SHALL have port out_valid, output, 1, result register holds a valid result.
REQ-010 The block SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 The block SHALL have port out_y, output, WIDTH, registered bitwise XOR result.
REQ-012 The block SHALL have port out_id, output, clog2(NREQ), index of the requester that produced out_y.
REQ-013 The block SHALL have port op_count, output, 16, total accepted operations; wraps 0xFFFF->0x0000.

Function
REQ-014 The block SHALL implement a two-state FSM: EMPTY (no held result) and FULL (result held).
REQ-015 The block SHALL define can_accept = (state==EMPTY) or (out_ready==1).
REQ-016 The block SHALL, when can_accept and any req_valid bit is set, assert req_ready for exactly one requester, chosen round-robin.
REQ-017 The block SHALL compute round-robin priority from a pointer ptr: search starts at ptr and wraps modulo NREQ.
REQ-018 The block SHALL, after granting requester g, set ptr to (g+1) mod NREQ on the next edge; ptr holds when nothing is granted.
REQ-019 The block SHALL keep req_ready combinational from req_valid, ptr, state and out_ready; req_ready SHALL be all-zero when can_accept is 0.
REQ-020 The block SHALL transfer on an edge where req_valid[g] and req_ready[g] are both 1: out_y <= a_g XOR b_g, out_id <= g, out_valid <= 1, FSM -> FULL; latency is 1 cycle.
REQ-021 The block SHALL, in FULL with out_ready=1 and no new grant, clear out_valid and go to EMPTY.
REQ-022 The block SHALL, in FULL with out_ready=1 and a new grant on the same edge, load the new result and stay FULL (back-to-back, 1 result/cycle).
REQ-023 The block SHALL, in FULL with out_ready=0, hold out_y, out_id and out_valid stable.
REQ-024 The block SHALL increment op_count by 1 on every accepted request.
REQ-025 The block SHALL ignore req_a/req_b of non-granted requesters; a non-granted requester keeps its request pending.

Reset
REQ-026 The block SHALL, on any edge with rst=1, including mid-transfer, set FSM=EMPTY, out_valid=0, out_y=0, out_id=0, ptr=0, op_count=0, and discard any held result.
REQ-027 The block SHALL hold req_ready all-zero while rst=1.

Structure
REQ-028 The block SHALL take FSM state encodings (EMPTY=0, FULL=1) and the op_count width (16) from shared package xor_arb_pkg.
REQ-029 The block SHALL place the round-robin grant logic in sub-module rr_arbiter (inputs req, ptr; output one-hot grant). The bitwise XOR SHALL be a WIDTH-wide xor_gate datapath instance or an equivalent expression.

Verification
REQ-030 The bench SHALL check: after reset, only req_valid=4'b0001, a=8'hA5, b=8'h0F, out_ready=1. Required: req_ready=4'b0001; the next cycle out_valid=1, out_y=8'hAA, out_id=0, op_count=1.
REQ-031 The bench SHALL check: req_valid=4'b1111 held for 4 cycles, out_ready=1. Required: grants in order 0,1,2,3; out_id in order 0,1,2,3 on consecutive cycles; op_count=4.
REQ-032 The bench SHALL check: out_ready=0 for 3 cycles with out_valid=1 and req_valid=4'b0010. Required: req_ready=0, out_y/out_id stable; out_ready=1 gives req_ready=4'b0010 on the same cycle.
REQ-033 The bench SHALL check: ptr=3 with req_valid=4'b1001. Required: grant requester 3, then requester 0 (wrap-around).
REQ-034 The bench SHALL check: rst=1 for one cycle while FULL with op_count=5. Required: next cycle out_valid=0, out_y=0, op_count=0, and the next grant goes to the lowest-index valid requester.
REQ-035 The bench SHALL check: 65536 accepted operations. Required: op_count wraps to 16'h0000 with no effect on out_valid.

Source files
------------

// File: rtl/xor_arb_pkg.sv
// Shared definitions for the XOR arbiter: FSM encoding and counter width.
package xor_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int OP_COUNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest-index request at or after ptr wins, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] req_rot;
  logic [NREQ-1:0]   req_low;
  logic [NREQ-1:0]   pick;
  logic [2*NREQ-1:0] pick_dbl;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl  = {req, req};
    req_rot  = req_dbl >> ptr;
    req_low  = req_rot[NREQ-1:0];
    pick     = req_low & (~req_low + {{(NREQ-1){1'b0}}, 1'b1});
    pick_dbl = {pick, pick} << ptr;
    grant    = pick_dbl[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/xor_arbiter.sv
// NREQ-way round-robin arbiter feeding a one-entry registered XOR result stage.
module xor_arbiter
  import xor_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic [OP_COUNT_W-1:0]    op_count
);

  localparam int ID_W = $clog2(NREQ);

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       ptr_reg;
  logic [WIDTH-1:0]      y_reg;
  logic [ID_W-1:0]       id_reg;
  logic [OP_COUNT_W-1:0] count_reg;

  logic                  can_accept;
  logic [NREQ-1:0]       arb_req;
  logic [NREQ-1:0]       grant;
  logic                  fire;
  logic [WIDTH-1:0]      sel_y;
  logic [ID_W-1:0]       sel_id;
  logic [WIDTH-1:0]      xor_vec [NREQ];

  // Requests are masked while the result slot cannot take a new value or during reset.
  assign can_accept = (state_reg == EMPTY) || out_ready;
  assign arb_req    = (can_accept && !rst) ? req_valid : '0;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (ID_W)
  ) u_rr (
    .req   (arb_req),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  assign req_ready = grant;
  assign fire      = |grant;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_xor
      assign xor_vec[gi] = req_a[gi*WIDTH +: WIDTH] ^ req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    sel_y  = '0;
    sel_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_y  = sel_y | xor_vec[k];
        sel_id = ID_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (fire) state_next = FULL;
      FULL:    if (!fire && out_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_reg == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= '0;
      y_reg     <= '0;
      id_reg    <= '0;
      count_reg <= '0;
    end else if (fire) begin
      y_reg     <= sel_y;
      id_reg    <= sel_id;
      count_reg <= count_reg + 1'b1;
      if (int'(sel_id) == NREQ - 1) ptr_reg <= '0;
      else                          ptr_reg <= sel_id + 1'b1;
    end
  end

  assign out_y    = y_reg;
  assign out_id   = id_reg;
  assign op_count = count_reg;

endmodule

// File: tb/tb_xor_arbiter.sv
// Directed bench for xor_arbiter with hand-computed expected values.
module tb_xor_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_y;
  logic [1:0]  out_id;
  logic [15:0] op_count;

  int n_cmp = 0;
  int n_err = 0;

  xor_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Operand slices: results are 11, DD, C3, 4B for requesters 0..3 (slice 0 overridden in places).
  logic [7:0] exp_y [4] = '{8'h11, 8'hDD, 8'hC3, 8'h4B};

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b0;
    tick();
    tick();

    // Requests and out_ready present while reset is held: no grant allowed.
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    check_eq("rst_req_ready", req_ready, 4'b0000);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_y", out_y, 8'h00);
    check_eq("rst_op_count", op_count, 16'h0000);
    req_valid = 4'b0000;
    tick();
    rst = 1'b0;

    // Single request from requester 0.
    req_a[7:0] = 8'hA5;
    req_b[7:0] = 8'h0F;
    req_valid  = 4'b0001;
    #1;
    check_eq("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    check_eq("single_valid", out_valid, 1'b1);
    check_eq("single_y", out_y, 8'hAA);
    check_eq("single_id", out_id, 2'd0);
    check_eq("single_count", op_count, 16'd1);
    tick();
    check_eq("drain_valid", out_valid, 1'b0);

    // All four requesting: rotation 0,1,2,3 from a fresh pointer.
    do_reset();
    req_a = {8'h44, 8'h33, 8'h22, 8'h11};
    req_b = {8'h0F, 8'hF0, 8'hFF, 8'h00};
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq($sformatf("rr_ready%0d", k), req_ready, 32'(4'b0001 << k));
      tick();
      check_eq($sformatf("rr_id%0d", k), out_id, k);
      check_eq($sformatf("rr_y%0d", k), out_y, exp_y[k]);
    end
    req_valid = 4'b0000;
    check_eq("rr_count", op_count, 16'd4);
    tick();

    // Backpressure: result held while out_ready is low.
    req_a[7:0] = 8'h5A;
    req_b[7:0] = 8'hFF;
    req_valid  = 4'b0001;
    tick();
    check_eq("bp_load_y", out_y, 8'hA5);
    out_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("bp_ready%0d", k), req_ready, 4'b0000);
      tick();
      check_eq($sformatf("bp_y%0d", k), out_y, 8'hA5);
      check_eq($sformatf("bp_id%0d", k), out_id, 2'd0);
      check_eq($sformatf("bp_valid%0d", k), out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", req_ready, 4'b0010);
    tick();
    check_eq("bp_new_y", out_y, 8'hDD);
    check_eq("bp_new_id", out_id, 2'd1);
    check_eq("bp_count", op_count, 16'd6);

    // Move pointer to 3, then wrap-around from 3 to 0.
    req_valid = 4'b0100;
    tick();
    check_eq("wrap_pre_id", out_id, 2'd2);
    req_valid = 4'b1001;
    #1;
    check_eq("wrap_ready3", req_ready, 4'b1000);
    tick();
    check_eq("wrap_id3", out_id, 2'd3);
    check_eq("wrap_y3", out_y, 8'h4B);
    #1;
    check_eq("wrap_ready0", req_ready, 4'b0001);
    tick();
    check_eq("wrap_id0", out_id, 2'd0);
    check_eq("wrap_y0", out_y, 8'hA5);
    check_eq("wrap_count", op_count, 16'd9);
    req_valid = 4'b0000;
    tick();

    // Reset while FULL with op_count=5.
    do_reset();
    req_valid = 4'b1111;
    repeat (5) tick();
    check_eq("midrst_pre_count", op_count, 16'd5);
    check_eq("midrst_pre_valid", out_valid, 1'b1);
    req_valid = 4'b0110;
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b0;
    check_eq("midrst_valid", out_valid, 1'b0);
    check_eq("midrst_y", out_y, 8'h00);
    check_eq("midrst_id", out_id, 2'd0);
    check_eq("midrst_count", op_count, 16'd0);
    #1;
    check_eq("midrst_next_ready", req_ready, 4'b0010);
    tick();
    check_eq("midrst_next_id", out_id, 2'd1);
    check_eq("midrst_next_y", out_y, 8'hDD);
    req_valid = 4'b0000;
    tick();

    // Counter wrap after 65536 accepted operations.
    do_reset();
    req_valid = 4'b0001;
    repeat (65535) tick();
    check_eq("wrap16_pre", op_count, 16'hFFFF);
    tick();
    check_eq("wrap16_count", op_count, 16'h0000);
    check_eq("wrap16_valid", out_valid, 1'b1);
    req_valid = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
